// File: rtl/return_addr_stack.sv
//-----------------------------------------------------------------------------
// return_addr_stack
//
// Return-address stack for the fetch stage. Calls push their return address
// (call pc + 8). Returns pop it. The current top of stack is presented
// combinationally as the predicted JR target.
//
// Storage is a circular array of RAS_DEPTH entries. The stack is tracked by a
// top-of-stack pointer (tos) and an occupancy counter (count, 0..RAS_DEPTH).
// A push into a full stack wraps around and overwrites the oldest entry. The
// count saturates at RAS_DEPTH, and no error is flagged.
//
// Configuration macro:
//   RAS_CKPT_EN - when defined, the tos/count state is exported for
//                 checkpointing, and recover_i restores it from recoverTos_i /
//                 recoverCnt_i. Entry contents are left untouched.
//                 When undefined, those four ports are absent and recover_i
//                 simply empties the stack.
//
// Parameters:
//   RAS_DEPTH   number of entries (power of two)
//   RAS_PTR     log2(RAS_DEPTH), width of the top-of-stack pointer
//   SIZE_PC     program-counter width
//
// Ports:
//   clk           sole clock, rising edge
//   reset         asynchronous active-low reset
//   stall_i       hold all state, ignore push/pop
//   pushValid_i   call seen at fetch
//   pushAddr_i    return address to push
//   popValid_i    return seen at fetch
//   recover_i     branch-mispredict recovery pulse (highest priority)
//   recoverTos_i  checkpointed pointer        (RAS_CKPT_EN only)
//   recoverCnt_i  checkpointed occupancy      (RAS_CKPT_EN only)
//   tos_o         current pointer             (RAS_CKPT_EN only)
//   count_o       current occupancy           (RAS_CKPT_EN only)
//   rasTop_o      predicted return target, 0 when empty
//   rasValid_o    stack holds at least one entry
//-----------------------------------------------------------------------------
module return_addr_stack #(
    parameter int RAS_DEPTH = 16,
    parameter int RAS_PTR   = 4,
    parameter int SIZE_PC   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_i,
    input  logic               pushValid_i,
    input  logic [SIZE_PC-1:0] pushAddr_i,
    input  logic               popValid_i,
    input  logic               recover_i,
`ifdef RAS_CKPT_EN
    input  logic [RAS_PTR-1:0] recoverTos_i,
    input  logic [RAS_PTR:0]   recoverCnt_i,
    output logic [RAS_PTR-1:0] tos_o,
    output logic [RAS_PTR:0]   count_o,
`endif
    output logic [SIZE_PC-1:0] rasTop_o,
    output logic               rasValid_o
);

    localparam int CNT_W = RAS_PTR + 1;

    // Registered state
    logic [SIZE_PC-1:0] entries_q [RAS_DEPTH];
    logic [RAS_PTR-1:0] tos_q,   tos_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Single write port into the entry array
    logic               wr_en;
    logic [RAS_PTR-1:0] wr_idx;
    logic [SIZE_PC-1:0] wr_data;

    // Pointer neighbours. RAS_DEPTH is a power of two, so the natural
    // RAS_PTR-bit wrap implements the modulo.
    logic [RAS_PTR-1:0] tos_inc;
    logic [RAS_PTR-1:0] tos_dec;
    logic               stack_empty;
    logic               stack_full;

    assign tos_inc     = tos_q + RAS_PTR'(1);
    assign tos_dec     = tos_q - RAS_PTR'(1);
    assign stack_empty = (count_q == '0);
    assign stack_full  = (count_q == CNT_W'(RAS_DEPTH));

    //-------------------------------------------------------------------------
    // Next-state logic
    // Priority order: recover, then stall, then push/pop.
    //-------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so that no
        // path leaves a signal unassigned. This prevents latch inference.
        tos_d   = tos_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_idx  = tos_q;
        wr_data = pushAddr_i;

        if (recover_i) begin
`ifdef RAS_CKPT_EN
            tos_d   = recoverTos_i;
            count_d = recoverCnt_i;
`else
            tos_d   = '0;
            count_d = '0;
`endif
        end else if (!stall_i) begin
            if (pushValid_i && popValid_i && !stack_empty) begin
                // A return immediately followed by a call replaces the top
                // entry in place. Depth is unchanged.
                wr_en  = 1'b1;
                wr_idx = tos_q;
            end else if (pushValid_i) begin
                // This branch also covers push+pop on an empty stack, since
                // there is nothing to pop. When full, the write lands on the
                // oldest slot and count saturates.
                tos_d  = tos_inc;
                wr_en  = 1'b1;
                wr_idx = tos_inc;
                if (!stack_full) begin
                    count_d = count_q + CNT_W'(1);
                end
            end else if (popValid_i && !stack_empty) begin
                tos_d   = tos_dec;
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    //-------------------------------------------------------------------------
    // State registers
    //-------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tos_q   <= '0;
            count_q <= '0;
            // NOTE: the entry array sits inside the async reset on purpose.
            // Every slot must read 0 after reset, so it is built from
            // resettable flops rather than a RAM macro.
            for (int i = 0; i < RAS_DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments only. All
            // flops then sample their _d values from before the edge,
            // regardless of statement order.
            tos_q   <= tos_d;
            count_q <= count_d;
            if (wr_en) begin
                entries_q[wr_idx] <= wr_data;
            end
        end
    end

    //-------------------------------------------------------------------------
    // Outputs: combinational from registered state only
    //-------------------------------------------------------------------------
    assign rasValid_o = !stack_empty;
    assign rasTop_o   = stack_empty ? '0 : entries_q[tos_q];

`ifdef RAS_CKPT_EN
    assign tos_o   = tos_q;
    assign count_o = count_q;
`endif

endmodule

// File: tb/tb_return_addr_stack.sv
//-----------------------------------------------------------------------------
// tb_return_addr_stack
//
// Directed bench for return_addr_stack. Each vector drives one cycle of
// stimulus. Outputs are sampled 1 time unit after the rising edge and compared
// with hand-computed expected values. Builds with or without RAS_CKPT_EN.
//-----------------------------------------------------------------------------
module tb_return_addr_stack;

    localparam int RAS_DEPTH = 16;
    localparam int RAS_PTR   = 4;
    localparam int SIZE_PC   = 32;

    logic               clk;
    logic               reset;
    logic               stall_i;
    logic               pushValid_i;
    logic [SIZE_PC-1:0] pushAddr_i;
    logic               popValid_i;
    logic               recover_i;
`ifdef RAS_CKPT_EN
    logic [RAS_PTR-1:0] recoverTos_i;
    logic [RAS_PTR:0]   recoverCnt_i;
    logic [RAS_PTR-1:0] tos_o;
    logic [RAS_PTR:0]   count_o;
`endif
    logic [SIZE_PC-1:0] rasTop_o;
    logic               rasValid_o;

    int n_checks = 0;
    int n_errors = 0;

    return_addr_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .RAS_PTR   (RAS_PTR),
        .SIZE_PC   (SIZE_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall_i     (stall_i),
        .pushValid_i (pushValid_i),
        .pushAddr_i  (pushAddr_i),
        .popValid_i  (popValid_i),
        .recover_i   (recover_i),
`ifdef RAS_CKPT_EN
        .recoverTos_i(recoverTos_i),
        .recoverCnt_i(recoverCnt_i),
        .tos_o       (tos_o),
        .count_o     (count_o),
`endif
        .rasTop_o    (rasTop_o),
        .rasValid_o  (rasValid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus and return 1 unit after the rising edge,
    // with the strobes cleared again.
    task automatic step(input logic push, input logic pop, input logic stall,
                        input logic rec, input logic [31:0] addr);
        pushValid_i = push;
        popValid_i  = pop;
        stall_i     = stall;
        recover_i   = rec;
        pushAddr_i  = addr;
        @(posedge clk);
        #1;
        pushValid_i = 1'b0;
        popValid_i  = 1'b0;
        stall_i     = 1'b0;
        recover_i   = 1'b0;
        pushAddr_i  = '0;
    endtask

    task automatic do_push(input logic [31:0] addr);
        step(1'b1, 1'b0, 1'b0, 1'b0, addr);
    endtask

    task automatic do_pop();
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        reset       = 1'b0;
        stall_i     = 1'b0;
        pushValid_i = 1'b0;
        pushAddr_i  = '0;
        popValid_i  = 1'b0;
        recover_i   = 1'b0;
`ifdef RAS_CKPT_EN
        recoverTos_i = '0;
        recoverCnt_i = '0;
`endif

        // ---- reset state ----
        #2;
        check("reset_top", rasTop_o, 32'h0);
        check("reset_valid", {31'b0, rasValid_o}, 32'h1 - 32'h1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_valid", {31'b0, rasValid_o}, 32'h0);

        // ---- single push / pop ----
        do_push(32'h0040_0008);
        check("push1_top", rasTop_o, 32'h0040_0008);
        check("push1_valid", {31'b0, rasValid_o}, 32'h1);
        do_pop();
        check("pop1_valid", {31'b0, rasValid_o}, 32'h0);
        check("pop1_top", rasTop_o, 32'h0);

        // ---- overflow: 17 pushes, count saturates at 16 ----
        for (int k = 0; k <= 16; k++) begin
            do_push(32'h100 + 32'(8 * k));
            check($sformatf("ovf_push%0d_top", k), rasTop_o, 32'h100 + 32'(8 * k));
        end
        // The oldest entry (0x100) was overwritten. 16 pops expose 0x180..0x108.
        for (int j = 0; j < 16; j++) begin
            check($sformatf("ovf_pop%0d_top", j), rasTop_o, 32'h180 - 32'(8 * j));
            check($sformatf("ovf_pop%0d_valid", j), {31'b0, rasValid_o}, 32'h1);
            do_pop();
        end
        check("ovf_empty_valid", {31'b0, rasValid_o}, 32'h0);
        check("ovf_empty_top", rasTop_o, 32'h0);
        do_pop();
        check("underflow_valid", {31'b0, rasValid_o}, 32'h0);
        check("underflow_top", rasTop_o, 32'h0);

        // ---- simultaneous push + pop ----
        do_push(32'h1f0);
        do_push(32'h200);
        check("pp_pre_top", rasTop_o, 32'h200);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h300);
        check("pp_top", rasTop_o, 32'h300);
        do_pop();
        check("pp_depth_top", rasTop_o, 32'h1f0);
        do_pop();
        check("pp_drain_valid", {31'b0, rasValid_o}, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h300);
        check("pp_empty_top", rasTop_o, 32'h300);
        check("pp_empty_valid", {31'b0, rasValid_o}, 32'h1);
        do_pop();
        check("pp_empty_cnt1", {31'b0, rasValid_o}, 32'h0);

        // ---- stall and recover priority ----
        do_push(32'h111);
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h444);
        check("stall_push_top", rasTop_o, 32'h111);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        check("stall_pop_top", rasTop_o, 32'h111);
        check("stall_pop_valid", {31'b0, rasValid_o}, 32'h1);
        do_pop();
        check("stall_cnt_valid", {31'b0, rasValid_o}, 32'h0);
        do_push(32'h111);
`ifdef RAS_CKPT_EN
        recoverTos_i = '0;
        recoverCnt_i = '0;
`endif
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h555);
        check("recover_wins_valid", {31'b0, rasValid_o}, 32'h0);
        check("recover_wins_top", rasTop_o, 32'h0);

`ifdef RAS_CKPT_EN
        // ---- checkpoint / restore ----
        recoverTos_i = 4'hf;
        recoverCnt_i = '0;
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        do_push(32'ha00);
        do_push(32'ha08);
        do_push(32'ha10);
        do_push(32'ha18);
        check("ckpt_tos", 32'(tos_o), 32'd3);
        check("ckpt_cnt", 32'(count_o), 32'd4);
        check("ckpt_top", rasTop_o, 32'ha18);
        do_push(32'hb00);
        do_push(32'hb08);
        do_pop();
        check("ckpt_spec_top", rasTop_o, 32'hb00);
        recoverTos_i = 4'd3;
        recoverCnt_i = 5'd4;
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        check("ckpt_rest_top", rasTop_o, 32'ha18);
        check("ckpt_rest_tos", 32'(tos_o), 32'd3);
        check("ckpt_rest_cnt", 32'(count_o), 32'd4);
        recoverTos_i = '0;
        recoverCnt_i = '0;
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
`else
        do_push(32'ha00);
        do_push(32'ha08);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        check("recover_clear_valid", {31'b0, rasValid_o}, 32'h0);
        check("recover_clear_top", rasTop_o, 32'h0);
`endif

        // ---- asynchronous reset mid-sequence ----
        for (int k = 0; k < 5; k++) begin
            do_push(32'h700 + 32'(4 * k));
        end
        check("pre_areset_top", rasTop_o, 32'h710);
        #3;
        reset       = 1'b0;
        pushValid_i = 1'b1;
        pushAddr_i  = 32'h999;
        #1;
        check("areset_top", rasTop_o, 32'h0);
        check("areset_valid", {31'b0, rasValid_o}, 32'h0);
        @(posedge clk);
        #1;
        check("areset_hold_top", rasTop_o, 32'h0);
        #2;
        reset       = 1'b1;
        pushValid_i = 1'b0;
        pushAddr_i  = '0;
        #1;
        check("areset_release_valid", {31'b0, rasValid_o}, 32'h0);
        do_push(32'h600);
        check("after_reset_top", rasTop_o, 32'h600);
        do_pop();
        check("after_reset_cnt", {31'b0, rasValid_o}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
